// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath and its controller:
// mux selects, opcode and function values, and a sign-extension helper.
package mc_pkg;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b10;
    localparam logic [1:0] PC_SRC_A      = 2'b11;

    localparam logic [1:0] REG_DST_RT    = 2'b00;
    localparam logic [1:0] REG_DST_RD    = 2'b01;
    localparam logic [1:0] REG_DST_RA    = 2'b10;
    localparam logic [1:0] REG_DST_NONE  = 2'b11;

    localparam logic [1:0] REG_WDST_ALUOUT = 2'b00;
    localparam logic [1:0] REG_WDST_MDR    = 2'b01;
    localparam logic [1:0] REG_WDST_PC     = 2'b10;
    localparam logic [1:0] REG_WDST_ZERO   = 2'b11;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_JR  = 6'h08;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_SLT = 6'h2A;

    localparam logic [4:0] RA_ADDR  = 5'd31;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// r0 is hardwired to zero on read and never stored.
module mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Reads see the stored value, so a same-edge write is visible only afterwards.
    assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs_q[raddr_b];

endmodule

// File: rtl/mc_datapath_regs.sv
// Multicycle datapath state: PC, IR, MDR, A, B, ALUOut, register file and
// the operand/address/writeback muxes steered by the controller.
module mc_datapath_regs
    import mc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_write,
    input  logic        reg_write,
    input  logic        l_or_d,
    input  logic        alusrcA,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  reg_dst,
    input  logic [1:0]  reg_wdst,
    input  logic [1:0]  alusrcB,
    input  logic [1:0]  pc_src,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] ir
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, a_q, b_q, aluout_q;
    logic [31:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we;
    logic        pc_en;
    logic [31:0] imm_ext;

    assign pc_en   = pc_write | (pc_write_cond & alu_zero);
    assign imm_ext = sext16(ir_q[15:0]);
    assign ir_d    = ir_write ? mem_rdata : ir_q;

    always_comb begin
        pc_d = pc_q;
        if (pc_en) begin
            case (pc_src)
                PC_SRC_ALU:    pc_d = alu_result;
                PC_SRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                PC_SRC_ALUOUT: pc_d = aluout_q;
                default:       pc_d = a_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_RESET;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mem_rdata;
            aluout_q <= alu_result;
            a_q      <= rf_rdata_a;
            b_q      <= rf_rdata_b;
        end
    end

    always_comb begin
        rf_waddr = ir_q[20:16];
        case (reg_dst)
            REG_DST_RT: rf_waddr = ir_q[20:16];
            REG_DST_RD: rf_waddr = ir_q[15:11];
            REG_DST_RA: rf_waddr = RA_ADDR;
            default:    rf_waddr = 5'd0;
        endcase
    end

    assign rf_we = reg_write & (reg_dst != REG_DST_NONE);

    // Writing pc_q (not pc_d) is what gives jal the return address of the current PC.
    always_comb begin
        rf_wdata = 32'h0;
        case (reg_wdst)
            REG_WDST_ALUOUT: rf_wdata = aluout_q;
            REG_WDST_MDR:    rf_wdata = mdr_q;
            REG_WDST_PC:     rf_wdata = pc_q;
            default:         rf_wdata = 32'h0;
        endcase
    end

    mc_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ir_q[25:21]),
        .raddr_b (ir_q[20:16]),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_comb begin
        alu_b = b_q;
        case (alusrcB)
            ALUB_B:    alu_b = b_q;
            ALUB_FOUR: alu_b = 32'd4;
            ALUB_IMM:  alu_b = imm_ext;
            default:   alu_b = {imm_ext[29:0], 2'b00};
        endcase
    end

    assign mem_addr  = l_or_d ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign alu_a     = alusrcA ? a_q : pc_q;
    assign opcode    = ir_q[31:26];
    assign func      = ir_q[5:0];
    assign pc        = pc_q;
    assign ir        = ir_q;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed bench for mc_datapath_regs; register-file contents are observed through A/B.
module tb_mc_datapath_regs;

    localparam logic [31:0] PCR = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_write, reg_write, l_or_d, alusrcA, pc_write, pc_write_cond;
    logic [1:0]  reg_dst, reg_wdst, alusrcB, pc_src;
    logic [31:0] mem_rdata, alu_result;
    logic        alu_zero;
    logic [31:0] mem_addr, mem_wdata, alu_a, alu_b, pc, ir;
    logic [5:0]  opcode, func;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_datapath_regs #(.PC_RESET(PCR)) dut (
        .clk(clk), .rst(rst),
        .ir_write(ir_write), .reg_write(reg_write), .l_or_d(l_or_d),
        .alusrcA(alusrcA), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .reg_dst(reg_dst), .reg_wdst(reg_wdst), .alusrcB(alusrcB), .pc_src(pc_src),
        .mem_rdata(mem_rdata), .alu_result(alu_result), .alu_zero(alu_zero),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_a(alu_a), .alu_b(alu_b),
        .opcode(opcode), .func(func), .pc(pc), .ir(ir)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ir_write = 0; reg_write = 0; l_or_d = 0; alusrcA = 0;
        pc_write = 0; pc_write_cond = 0; alu_zero = 0;
        reg_dst = 2'b00; reg_wdst = 2'b00; alusrcB = 2'b00; pc_src = 2'b00;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; ir_write = 1; reg_write = 1; pc_write = 1;
        mem_rdata = 32'hDEAD_BEEF; alu_result = 32'h1234_5678;
        step(); step();
        n_checks++; if (pc !== PCR) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, PCR); end
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h expected %h", ir, 32'h0); end
        idle(); l_or_d = 1; alusrcA = 1; #1;
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_aluout: got %h expected %h", mem_addr, 32'h0); end
        n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL reset_a: got %h expected %h", alu_a, 32'h0); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_b: got %h expected %h", mem_wdata, 32'h0); end
        idle(); rst = 0; mem_rdata = 32'h0; alu_result = 32'h0;
        step();
        n_checks++; if (mem_addr !== PCR) begin n_fail++; $display("FAIL post_reset_mem_addr: got %h expected %h", mem_addr, PCR); end
        n_checks++; if (opcode !== 6'h00 || func !== 6'h00) begin n_fail++; $display("FAIL post_reset_op_func: got %h/%h expected 00/00", opcode, func); end
    endtask

    task automatic test_fetch();
        idle(); mem_rdata = 32'h2009_0005; ir_write = 1; pc_write = 1; pc_src = 2'b00; alu_result = 32'd4;
        step();
        n_checks++; if (ir !== 32'h2009_0005) begin n_fail++; $display("FAIL fetch_ir: got %h expected %h", ir, 32'h2009_0005); end
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL fetch_pc: got %h expected %h", pc, 32'h4); end
        n_checks++; if (opcode !== 6'h08 || func !== 6'h05) begin n_fail++; $display("FAIL fetch_op_func: got %h/%h expected 08/05", opcode, func); end
        idle(); mem_rdata = 32'hFFFF_FFFF; alu_result = 32'h77;
        step();
        n_checks++; if (ir !== 32'h2009_0005) begin n_fail++; $display("FAIL ir_hold: got %h expected %h", ir, 32'h2009_0005); end
        n_checks++; if (alu_a !== 32'h4) begin n_fail++; $display("FAIL pc_hold_alu_a: got %h expected %h", alu_a, 32'h4); end
    endtask

    task automatic test_alub();
        idle(); alusrcB = 2'b01; #1;
        n_checks++; if (alu_b !== 32'd4) begin n_fail++; $display("FAIL alub_four: got %h expected %h", alu_b, 32'd4); end
        alusrcB = 2'b10; #1;
        n_checks++; if (alu_b !== 32'd5) begin n_fail++; $display("FAIL alub_imm_pos: got %h expected %h", alu_b, 32'd5); end
        alusrcB = 2'b11; #1;
        n_checks++; if (alu_b !== 32'd20) begin n_fail++; $display("FAIL alub_imm_sh_pos: got %h expected %h", alu_b, 32'd20); end
        idle(); mem_rdata = 32'h2009_FFF0; ir_write = 1;
        step();
        idle(); alusrcB = 2'b10; #1;
        n_checks++; if (alu_b !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL alub_imm_neg: got %h expected %h", alu_b, 32'hFFFF_FFF0); end
        alusrcB = 2'b11; #1;
        n_checks++; if (alu_b !== 32'hFFFF_FFC0) begin n_fail++; $display("FAIL alub_imm_sh_neg: got %h expected %h", alu_b, 32'hFFFF_FFC0); end
    endtask

    task automatic test_writeback();
        idle(); mem_rdata = 32'h0000_4820; ir_write = 1; alu_result = 32'h7;
        step();
        idle(); alu_result = 32'h0; reg_write = 1; reg_dst = 2'b01; reg_wdst = 2'b00;
        step();
        idle(); mem_rdata = 32'h0129_0000; ir_write = 1;
        step();
        idle();
        step();
        alusrcA = 1; alusrcB = 2'b00; #1;
        n_checks++; if (mem_wdata !== 32'h7) begin n_fail++; $display("FAIL wb_b: got %h expected %h", mem_wdata, 32'h7); end
        n_checks++; if (alu_a !== 32'h7) begin n_fail++; $display("FAIL wb_a: got %h expected %h", alu_a, 32'h7); end
        n_checks++; if (alu_b !== 32'h7) begin n_fail++; $display("FAIL wb_alu_b: got %h expected %h", alu_b, 32'h7); end
        idle(); pc_write = 1; pc_src = 2'b11;
        step();
        n_checks++; if (pc !== 32'h7) begin n_fail++; $display("FAIL pc_src_a: got %h expected %h", pc, 32'h7); end
    endtask

    task automatic test_read_during_write();
        idle(); alu_result = 32'h55;
        step();
        reg_write = 1; reg_dst = 2'b00; reg_wdst = 2'b00;
        step();
        n_checks++; if (mem_wdata !== 32'h7) begin n_fail++; $display("FAIL rdw_old: got %h expected %h", mem_wdata, 32'h7); end
        idle();
        step();
        n_checks++; if (mem_wdata !== 32'h55) begin n_fail++; $display("FAIL rdw_new: got %h expected %h", mem_wdata, 32'h55); end
    endtask

    task automatic test_wdata_sources();
        idle(); mem_rdata = 32'hCAFE_F00D;
        step();
        reg_write = 1; reg_dst = 2'b00; reg_wdst = 2'b01;
        step();
        idle();
        step();
        n_checks++; if (mem_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wdst_mdr: got %h expected %h", mem_wdata, 32'hCAFE_F00D); end
        alu_result = 32'h99;
        step();
        reg_write = 1; reg_dst = 2'b11; reg_wdst = 2'b00;
        step();
        idle();
        step();
        n_checks++; if (mem_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL regdst_none: got %h expected %h", mem_wdata, 32'hCAFE_F00D); end
        reg_write = 1; reg_dst = 2'b00; reg_wdst = 2'b11;
        step();
        idle();
        step();
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL wdst_zero: got %h expected %h", mem_wdata, 32'h0); end
    endtask

    task automatic test_r0();
        idle(); mem_rdata = 32'h0; ir_write = 1; alu_result = 32'hFFFF;
        step();
        idle(); reg_write = 1; reg_dst = 2'b00; reg_wdst = 2'b00;
        step();
        idle();
        step();
        alusrcA = 1; #1;
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL r0_b: got %h expected %h", mem_wdata, 32'h0); end
        n_checks++; if (alu_a !== 32'h0) begin n_fail++; $display("FAIL r0_a: got %h expected %h", alu_a, 32'h0); end
    endtask

    task automatic test_branch();
        idle(); pc_write = 1; pc_src = 2'b00; alu_result = 32'h100;
        step();
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL br_setup_pc: got %h expected %h", pc, 32'h100); end
        idle(); pc_write_cond = 1; alu_zero = 0; pc_src = 2'b10; alu_result = 32'h40;
        step();
        n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL br_not_taken: got %h expected %h", pc, 32'h100); end
        l_or_d = 1; #1;
        n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL mem_addr_aluout: got %h expected %h", mem_addr, 32'h40); end
        l_or_d = 0; #1;
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL mem_addr_pc: got %h expected %h", mem_addr, 32'h100); end
        alu_zero = 1;
        step();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL br_taken: got %h expected %h", pc, 32'h40); end
        idle(); alu_zero = 1; alu_result = 32'h80;
        step();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL zero_without_cond: got %h expected %h", pc, 32'h40); end
    endtask

    task automatic test_jal();
        idle(); pc_write = 1; pc_src = 2'b00; alu_result = 32'h1000_0008; ir_write = 1; mem_rdata = 32'h0C00_0010;
        step();
        idle(); pc_write = 1; pc_src = 2'b01; reg_write = 1; reg_dst = 2'b10; reg_wdst = 2'b10;
        step();
        n_checks++; if (pc !== 32'h1000_0040) begin n_fail++; $display("FAIL jal_pc: got %h expected %h", pc, 32'h1000_0040); end
        idle(); mem_rdata = 32'h03FF_0000; ir_write = 1;
        step();
        idle();
        step();
        alusrcA = 1; #1;
        n_checks++; if (mem_wdata !== 32'h1000_0008) begin n_fail++; $display("FAIL jal_r31_b: got %h expected %h", mem_wdata, 32'h1000_0008); end
        n_checks++; if (alu_a !== 32'h1000_0008) begin n_fail++; $display("FAIL jal_r31_a: got %h expected %h", alu_a, 32'h1000_0008); end
    endtask

    task automatic test_midop_reset();
        idle(); rst = 1; reg_write = 1; reg_dst = 2'b10; reg_wdst = 2'b10;
        pc_write = 1; pc_src = 2'b00; alu_result = 32'h1111_1111; ir_write = 1; mem_rdata = 32'hABCD_1234;
        step();
        n_checks++; if (pc !== PCR) begin n_fail++; $display("FAIL midrst_pc: got %h expected %h", pc, PCR); end
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL midrst_ir: got %h expected %h", ir, 32'h0); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_b: got %h expected %h", mem_wdata, 32'h0); end
        rst = 0; idle(); mem_rdata = 32'h03FF_0000; ir_write = 1;
        step();
        idle();
        step();
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL midrst_r31: got %h expected %h", mem_wdata, 32'h0); end
        n_checks++; if (pc !== PCR) begin n_fail++; $display("FAIL midrst_pc_hold: got %h expected %h", pc, PCR); end
    endtask

    initial begin
        idle(); rst = 1; mem_rdata = '0; alu_result = '0;
        test_reset();
        test_fetch();
        test_alub();
        test_writeback();
        test_read_during_write();
        test_wdata_sources();
        test_r0();
        test_branch();
        test_jal();
        test_midop_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
